// File: rtl/seven_seg_pkg.sv
// Shared types and constants for the Basys3 seven-segment scanner.
package seven_seg_pkg;

    localparam int NUM_DIGITS = 4;

    typedef enum logic {BLANK, DRIVE} scan_state_t;

    // Active-low "everything off" patterns for the segment and anode pins.
    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [3:0] AN_OFF  = 4'hF;

endpackage

// File: rtl/hex7seg.sv
// Hex nibble to seven-segment decoder, active-high outputs, segments A..G in bits 0..6.
module hex7seg (
    input  logic [3:0] d_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = 7'h00;
        case (d_i)
            4'h0: seg_o = 7'h3F;
            4'h1: seg_o = 7'h06;
            4'h2: seg_o = 7'h5B;
            4'h3: seg_o = 7'h4F;
            4'h4: seg_o = 7'h66;
            4'h5: seg_o = 7'h6D;
            4'h6: seg_o = 7'h7D;
            4'h7: seg_o = 7'h07;
            4'h8: seg_o = 7'h7F;
            4'h9: seg_o = 7'h6F;
            4'hA: seg_o = 7'h77;
            4'hB: seg_o = 7'h7C;
            4'hC: seg_o = 7'h39;
            4'hD: seg_o = 7'h5E;
            4'hE: seg_o = 7'h79;
            4'hF: seg_o = 7'h71;
            default: seg_o = 7'h00;
        endcase
    end

endmodule

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed 4-digit common-anode display driver with a one-deep pending
// buffer that is committed to the displayed shadow only at frame boundaries.
module seven_seg_scanner
    import seven_seg_pkg::*;
#(
    parameter int CLK_HZ       = 100_000_000,
    parameter int DIGIT_HZ     = 1000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] value_i,
    input  logic [3:0]  digit_en_i,
    input  logic [3:0]  dp_i,
    input  logic        valid_i,
    output logic        ready_o,
    output logic [6:0]  seg_o,
    output logic        dp_o,
    output logic [3:0]  an_o,
    output logic        frame_o
);

    localparam int TICKS = CLK_HZ / DIGIT_HZ;
    localparam int CNT_W = $clog2(TICKS);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TICKS - 1);
    localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);
    localparam logic [1:0]       IDX_LAST  = 2'(NUM_DIGITS - 1);

    if (TICKS < 2 || BLANK_CYCLES < 1 || BLANK_CYCLES >= TICKS) begin : g_bad_params
        $error("seven_seg_scanner: need TICKS >= 2 and 1 <= BLANK_CYCLES < TICKS");
    end

    scan_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       idx_q, idx_d;

    logic [15:0] pend_val_q, pend_val_d;
    logic [3:0]  pend_en_q, pend_en_d;
    logic [3:0]  pend_dp_q, pend_dp_d;
    logic        pend_full_q, pend_full_d;
    logic [15:0] shd_val_q, shd_val_d;
    logic [3:0]  shd_en_q, shd_en_d;
    logic [3:0]  shd_dp_q, shd_dp_d;

    logic [6:0] seg_q, seg_d;
    logic       dp_q, dp_d;
    logic [3:0] an_q, an_d;
    logic       frame_q, frame_d;

    logic       wrap, boundary, take;
    logic [3:0] nibble;
    logic [6:0] hex_seg;

    hex7seg u_hex7seg (
        .d_i   (nibble),
        .seg_o (hex_seg)
    );

    assign nibble = shd_val_q[{idx_q, 2'b00} +: 4];

    always_comb begin
        wrap     = (cnt_q == CNT_LAST);
        boundary = wrap && (idx_q == IDX_LAST);
        take     = valid_i && !pend_full_q;

        cnt_d = wrap ? '0 : cnt_q + CNT_W'(1);
        idx_d = wrap ? idx_q + 2'd1 : idx_q;

        state_d = state_q;
        case (state_q)
            BLANK:   if (!wrap && cnt_d == CNT_BLANK) state_d = DRIVE;
            DRIVE:   if (wrap) state_d = BLANK;
            default: state_d = BLANK;
        endcase

        // take and a boundary commit never coincide: take needs the buffer empty.
        pend_val_d  = pend_val_q;
        pend_en_d   = pend_en_q;
        pend_dp_d   = pend_dp_q;
        pend_full_d = pend_full_q;
        if (take) begin
            pend_val_d  = value_i;
            pend_en_d   = digit_en_i;
            pend_dp_d   = dp_i;
            pend_full_d = 1'b1;
        end else if (boundary) begin
            pend_full_d = 1'b0;
        end

        shd_val_d = shd_val_q;
        shd_en_d  = shd_en_q;
        shd_dp_d  = shd_dp_q;
        if (boundary && pend_full_q) begin
            shd_val_d = pend_val_q;
            shd_en_d  = pend_en_q;
            shd_dp_d  = pend_dp_q;
        end

        // A disabled digit keeps segments and dp dark too, not just its anode.
        an_d  = AN_OFF;
        seg_d = SEG_OFF;
        dp_d  = 1'b1;
        if (state_q == DRIVE && shd_en_q[idx_q]) begin
            an_d[idx_q] = 1'b0;
            seg_d       = ~hex_seg;
            dp_d        = ~shd_dp_q[idx_q];
        end

        frame_d = boundary;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= BLANK;
            cnt_q       <= '0;
            idx_q       <= '0;
            pend_val_q  <= '0;
            pend_en_q   <= '0;
            pend_dp_q   <= '0;
            pend_full_q <= 1'b0;
            shd_val_q   <= '0;
            shd_en_q    <= '0;
            shd_dp_q    <= '0;
            seg_q       <= SEG_OFF;
            dp_q        <= 1'b1;
            an_q        <= AN_OFF;
            frame_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            pend_val_q  <= pend_val_d;
            pend_en_q   <= pend_en_d;
            pend_dp_q   <= pend_dp_d;
            pend_full_q <= pend_full_d;
            shd_val_q   <= shd_val_d;
            shd_en_q    <= shd_en_d;
            shd_dp_q    <= shd_dp_d;
            seg_q       <= seg_d;
            dp_q        <= dp_d;
            an_q        <= an_d;
            frame_q     <= frame_d;
        end
    end

    assign ready_o = ~pend_full_q;
    assign seg_o   = seg_q;
    assign dp_o    = dp_q;
    assign an_o    = an_q;
    assign frame_o = frame_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Directed bench for seven_seg_scanner with TICKS=10, BLANK_CYCLES=2 (40-cycle frame).
module tb_seven_seg_scanner;

    logic        clk;
    logic        rst_n;
    logic [15:0] value_i;
    logic [3:0]  digit_en_i;
    logic [3:0]  dp_i;
    logic        valid_i;
    logic        ready_o;
    logic [6:0]  seg_o;
    logic        dp_o;
    logic [3:0]  an_o;
    logic        frame_o;

    int checks;
    int failures;

    seven_seg_scanner #(
        .CLK_HZ       (1000),
        .DIGIT_HZ     (100),
        .BLANK_CYCLES (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .value_i    (value_i),
        .digit_en_i (digit_en_i),
        .dp_i       (dp_i),
        .valid_i    (valid_i),
        .ready_o    (ready_o),
        .seg_o      (seg_o),
        .dp_o       (dp_o),
        .an_o       (an_o),
        .frame_o    (frame_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [6:0] hex_ref(input logic [3:0] d);
        logic [6:0] t;
        case (d)
            4'h0: t = 7'b0111111;  4'h1: t = 7'b0000110;
            4'h2: t = 7'b1011011;  4'h3: t = 7'b1001111;
            4'h4: t = 7'b1100110;  4'h5: t = 7'b1101101;
            4'h6: t = 7'b1111101;  4'h7: t = 7'b0000111;
            4'h8: t = 7'b1111111;  4'h9: t = 7'b1101111;
            4'hA: t = 7'b1110111;  4'hB: t = 7'b1111100;
            4'hC: t = 7'b0111001;  4'hD: t = 7'b1011110;
            4'hE: t = 7'b1111001;  default: t = 7'b1110001;
        endcase
        return t;
    endfunction

    // j counts negedges after the frame_o pulse (1..40); the pins lag the scan by one cycle.
    function automatic logic [11:0] exp_pins(input logic [15:0] v, input logic [3:0] e,
                                             input logic [3:0] d, input int j);
        int s, k;
        logic [3:0] an;
        logic [3:0] nib;
        s = (j - 1) / 10;
        k = (j - 1) % 10;
        if (k < 2 || !e[s]) return {4'hF, 7'h7F, 1'b1};
        an    = 4'hF;
        an[s] = 1'b0;
        nib   = v[s*4 +: 4];
        return {an, ~hex_ref(nib), ~d[s]};
    endfunction

    task automatic check_frame(input logic [15:0] v, input logic [3:0] e, input logic [3:0] d,
                               input int j0, input int j1);
        for (int j = j0; j <= j1; j++) begin
            @(negedge clk);
            check_eq("pins", {an_o, seg_o, dp_o}, exp_pins(v, e, d, j));
            check_eq("frame_pulse", frame_o, (j == 40));
        end
    endtask

    task automatic idle_run();
        for (int n = 1; n <= 50; n++) begin
            @(negedge clk);
            check_eq("idle_pins", {an_o, seg_o, dp_o}, {4'hF, 7'h7F, 1'b1});
            check_eq("idle_frame", frame_o, (n == 40));
            check_eq("idle_ready", ready_o, 1'b1);
        end
    endtask

    task automatic send(input logic [15:0] v, input logic [3:0] e, input logic [3:0] d);
        int n;
        n          = 0;
        value_i    = v;
        digit_en_i = e;
        dp_i       = d;
        valid_i    = 1'b1;
        while (ready_o !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_eq("send_ready", ready_o, 1'b1);
        @(negedge clk);
        valid_i = 1'b0;
    endtask

    task automatic wait_frame();
        int n;
        n = 0;
        @(negedge clk);
        while (frame_o !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_eq("frame_seen", frame_o, 1'b1);
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        rst_n      = 1'b0;
        valid_i    = 1'b0;
        value_i    = '0;
        digit_en_i = '0;
        dp_i       = '0;
        repeat (3) @(negedge clk);
        check_eq("reset_pins", {an_o, seg_o, dp_o}, {4'hF, 7'h7F, 1'b1});
        check_eq("reset_frame", frame_o, 1'b0);
        check_eq("reset_ready", ready_o, 1'b1);
        rst_n = 1'b1;
        idle_run();

        // Single value, all digits on.
        send(16'h1234, 4'hF, 4'h0);
        check_eq("ready_after_take", ready_o, 1'b0);
        wait_frame();
        check_frame(16'h1234, 4'hF, 4'h0, 1, 40);

        // Partial enable mask with a decimal point.
        send(16'h00F0, 4'b0101, 4'b0001);
        wait_frame();
        check_frame(16'h00F0, 4'b0101, 4'b0001, 1, 40);

        // Back-to-back: B held from the start of the frame until the boundary.
        send(16'hAAAA, 4'hF, 4'h0);
        check_eq("ready_low_a", ready_o, 1'b0);
        value_i    = 16'hBBBB;
        digit_en_i = 4'hF;
        dp_i       = 4'b1000;
        valid_i    = 1'b1;
        check_frame(16'h00F0, 4'b0101, 4'b0001, 2, 40);
        check_eq("ready_at_frame", ready_o, 1'b1);
        @(negedge clk);
        valid_i = 1'b0;
        check_eq("ready_low_b", ready_o, 1'b0);
        check_frame(16'hAAAA, 4'hF, 4'h0, 2, 40);
        check_frame(16'hBBBB, 4'hF, 4'b1000, 1, 40);

        // valid_i raised exactly on the boundary cycle while pending is full.
        send(16'h5678, 4'hF, 4'h0);
        check_frame(16'hBBBB, 4'hF, 4'b1000, 2, 39);
        check_eq("ready_low_boundary", ready_o, 1'b0);
        value_i    = 16'h9CDE;
        digit_en_i = 4'hF;
        dp_i       = 4'b0100;
        valid_i    = 1'b1;
        check_frame(16'hBBBB, 4'hF, 4'b1000, 40, 40);
        check_eq("ready_after_boundary", ready_o, 1'b1);
        @(negedge clk);
        valid_i = 1'b0;
        check_eq("ready_low_d", ready_o, 1'b0);
        check_frame(16'h5678, 4'hF, 4'h0, 2, 40);
        check_frame(16'h9CDE, 4'hF, 4'b0100, 1, 40);

        // Asynchronous reset mid-DRIVE of digit 2 with a transfer pending.
        send(16'hFFFF, 4'hF, 4'hF);
        check_frame(16'h9CDE, 4'hF, 4'b0100, 2, 25);
        check_eq("drive_digit2", an_o, 4'b1011);
        #1 rst_n = 1'b0;
        #1;
        check_eq("async_pins", {an_o, seg_o, dp_o}, {4'hF, 7'h7F, 1'b1});
        check_eq("async_frame", frame_o, 1'b0);
        check_eq("async_ready", ready_o, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        idle_run();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
